// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control slice: FSM state encodings,
// port-address constants and the default WAIT_TILL_EMPTY timeout length.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_PORT0   = 2'd0;
    localparam logic [1:0] ADDR_PORT1   = 2'd1;
    localparam logic [1:0] ADDR_PORT2   = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    localparam int WAIT_LIMIT_DEFAULT = 32;

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for WAIT_TILL_EMPTY. Held at zero outside the wait state so it
// always starts from zero on entry; `expired` flags the WAIT_LIMIT-th cycle
// spent waiting.
module router_wait_timer
    import router_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic in_wait,
    output logic expired
);

    logic [4:0] count;

    // count cycles spent in the wait state, cleared whenever we are outside it
    always_ff @(posedge clock) begin
        if (!resetn)       count <= 5'd0;
        else if (!in_wait) count <= 5'd0;
        else               count <= count + 5'd1;
    end

    assign expired = in_wait && (count == 5'(WAIT_LIMIT - 1));

endmodule

// File: rtl/router_fsm.sv
// Packet-level control FSM of the 1x3 router. Decodes the header address,
// sequences header/payload/parity writes into the selected output FIFO,
// stalls on FIFO full and aborts on the selected port's soft reset.
// Optional WAIT_TILL_EMPTY timeout: define ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm
    import router_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic       wait_timeout
);

    if (WAIT_LIMIT < 2 || WAIT_LIMIT > 32) begin : g_bad_wait_limit
        $error("router_fsm: WAIT_LIMIT must be in 2..32");
    end

    state_t     state_q, state_d;
    logic [1:0] addr_q;
    logic       empty_sel, soft_sel, hdr_empty, hdr_ok, timeout_hit;

    // latch the destination of a valid header; it steers empty/soft-reset selection
    always_ff @(posedge clock) begin
        if (!resetn)
            addr_q <= ADDR_PORT0;
        else if (state_q == DECODE_ADDRESS && pkt_valid && data_in != ADDR_INVALID)
            addr_q <= data_in;
    end

    // per-port flag selection: latched address for in-packet states, live bus for the header
    always_comb begin
        empty_sel = 1'b0;
        soft_sel  = 1'b0;
        hdr_empty = 1'b0;
        case (addr_q)
            ADDR_PORT0: begin empty_sel = fifo_empty_0; soft_sel = soft_reset_0; end
            ADDR_PORT1: begin empty_sel = fifo_empty_1; soft_sel = soft_reset_1; end
            ADDR_PORT2: begin empty_sel = fifo_empty_2; soft_sel = soft_reset_2; end
            default:    ;
        endcase
        case (data_in)
            ADDR_PORT0: hdr_empty = fifo_empty_0;
            ADDR_PORT1: hdr_empty = fifo_empty_1;
            ADDR_PORT2: hdr_empty = fifo_empty_2;
            default:    ;
        endcase
    end

    assign hdr_ok = pkt_valid && (data_in != ADDR_INVALID);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    logic wait_expired;
    logic wait_timeout_q;

    router_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clock   (clock),
        .resetn  (resetn),
        .in_wait (state_q == WAIT_TILL_EMPTY),
        .expired (wait_expired)
    );

    assign timeout_hit = wait_expired;

    // pulse only when the timeout is what actually moves us out of the wait state
    always_ff @(posedge clock) begin
        if (!resetn) wait_timeout_q <= 1'b0;
        else         wait_timeout_q <= wait_expired && !empty_sel && !soft_sel;
    end

    assign wait_timeout = wait_timeout_q;
`else
    assign timeout_hit  = 1'b0;
    assign wait_timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clock) begin
        if (!resetn) state_q <= DECODE_ADDRESS;
        else         state_q <= state_d;
    end

    // next-state logic; the selected port's soft reset overrides every transition
    always_comb begin
        state_d = state_q;
        if (state_q != DECODE_ADDRESS && soft_sel) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS:
                    if (hdr_ok) state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:
                    state_d = LOAD_DATA;
                LOAD_DATA:
                    if (fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                FIFO_FULL_STATE:
                    if (!fifo_full) state_d = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:
                    if (parity_done)        state_d = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = LOAD_PARITY;
                    else                    state_d = LOAD_DATA;
                LOAD_PARITY:
                    state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR:
                    state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY:
                    if (empty_sel)        state_d = LOAD_FIRST_DATA;
                    else if (timeout_hit) state_d = DECODE_ADDRESS;
                default:
                    state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // Moore output decode from the state register
    always_comb begin
        detect_add    = (state_q == DECODE_ADDRESS);
        lfd_state     = (state_q == LOAD_FIRST_DATA);
        ld_state      = (state_q == LOAD_DATA);
        full_state    = (state_q == FIFO_FULL_STATE);
        laf_state     = (state_q == LOAD_AFTER_FULL);
        rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                        (state_q == LOAD_PARITY);
        busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
    end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed walk through the packet flows
// followed by randomized traffic, all compared cycle by cycle against a
// phase-level reference model of the packet protocol.
module tb_router_fsm;

    localparam int LIMIT = 4;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // output vector order: detect, lfd, ld, laf, full, we, rst_int, busy, timeout
    localparam logic [8:0] V_DET  = 9'b100000000;
    localparam logic [8:0] V_DETT = 9'b100000001;
    localparam logic [8:0] V_LFD  = 9'b010000010;
    localparam logic [8:0] V_LD   = 9'b001001000;
    localparam logic [8:0] V_LAF  = 9'b000101010;
    localparam logic [8:0] V_FULL = 9'b000010010;
    localparam logic [8:0] V_PAR  = 9'b000001010;
    localparam logic [8:0] V_CHK  = 9'b000000110;
    localparam logic [8:0] V_WAIT = 9'b000000010;

    logic       clock = 1'b0;
    logic       resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy, wait_timeout;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    router_fsm #(.WAIT_LIMIT(LIMIT)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .wait_timeout(wait_timeout)
    );

    // reference model: packet phases, in its own vocabulary
    typedef enum int {M_IDLE, M_WAITQ, M_HDR, M_BODY, M_STALL, M_RESUME, M_PAR, M_CHK} mph_t;
    mph_t       ph = M_IDLE, ph_n;
    logic [1:0] m_addr = 2'd0, m_addr_n;
    int         waited = 0, waited_n;
    bit         m_to = 1'b0, m_to_n;

    function automatic logic empty_of(input logic [1:0] a);
        return (a == 2'd0) ? fifo_empty_0 : (a == 2'd1) ? fifo_empty_1 :
               (a == 2'd2) ? fifo_empty_2 : 1'b0;
    endfunction

    function automatic logic sr_of(input logic [1:0] a);
        return (a == 2'd0) ? soft_reset_0 : (a == 2'd1) ? soft_reset_1 :
               (a == 2'd2) ? soft_reset_2 : 1'b0;
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [8:0] v;
        v    = '0;
        v[8] = (ph == M_IDLE);
        v[7] = (ph == M_HDR);
        v[6] = (ph == M_BODY);
        v[5] = (ph == M_RESUME);
        v[4] = (ph == M_STALL);
        v[3] = (ph == M_BODY) || (ph == M_RESUME) || (ph == M_PAR);
        v[2] = (ph == M_CHK);
        v[1] = !((ph == M_IDLE) || (ph == M_BODY));
        v[0] = m_to;
        return v;
    endfunction

    function automatic logic [8:0] dut_vec();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy, wait_timeout};
    endfunction

    task automatic model_next();
        ph_n = ph; m_addr_n = m_addr; waited_n = waited; m_to_n = 1'b0;
        if (!resetn) begin
            ph_n = M_IDLE; m_addr_n = 2'd0; waited_n = 0;
        end else if (ph != M_IDLE && sr_of(m_addr)) begin
            ph_n = M_IDLE;
        end else begin
            case (ph)
                M_IDLE: if (pkt_valid && data_in != 2'd3) begin
                    m_addr_n = data_in;
                    if (empty_of(data_in)) ph_n = M_HDR;
                    else begin ph_n = M_WAITQ; waited_n = 1; end
                end
                M_HDR:    ph_n = M_BODY;
                M_BODY:   if (fifo_full) ph_n = M_STALL; else if (!pkt_valid) ph_n = M_PAR;
                M_STALL:  if (!fifo_full) ph_n = M_RESUME;
                M_RESUME: if (parity_done) ph_n = M_IDLE;
                          else if (low_pkt_valid) ph_n = M_PAR;
                          else ph_n = M_BODY;
                M_PAR:    ph_n = M_CHK;
                M_CHK:    ph_n = fifo_full ? M_STALL : M_IDLE;
                M_WAITQ:  if (empty_of(m_addr)) ph_n = M_HDR;
                          else if (TO_EN && waited >= LIMIT) begin ph_n = M_IDLE; m_to_n = 1'b1; end
                          else waited_n = waited + 1;
                default:  ph_n = M_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // one clock: predict from current inputs, advance, compare everything against the model
    task automatic cyc(input string tag);
        model_next();
        @(posedge clock);
        #1;
        ph = ph_n; m_addr = m_addr_n; waited = waited_n; m_to = m_to_n;
        chk({tag, "/model"}, 32'(dut_vec()), 32'(exp_vec()));
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        // reset
        cyc("rst0");
        cyc("rst1");
        chk("reset_outputs", 32'(dut_vec()), 32'(V_DET));
        resetn = 1'b1;
        cyc("idle");
        chk("idle_after_reset", 32'(dut_vec()), 32'(V_DET));

        // packet to port 1: header, 4 payload cycles, parity, check, back to decode
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
        cyc("p1_hdr");
        chk("p1_lfd", 32'(dut_vec()), 32'(V_LFD));
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin cyc("p1_ld"); pkt_valid = 1'b0; end
            else cyc("p1_ld");
            chk("p1_ld_we", 32'(dut_vec()), 32'(V_LD));
        end
        cyc("p1_par");
        chk("p1_par", 32'(dut_vec()), 32'(V_PAR));
        cyc("p1_chk");
        chk("p1_rst_int", 32'(dut_vec()), 32'(V_CHK));
        cyc("p1_done");
        chk("p1_detect", 32'(dut_vec()), 32'(V_DET));

        // full stall on port 0
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
        cyc("f_hdr");
        cyc("f_ld");
        chk("f_ld", 32'(dut_vec()), 32'(V_LD));
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin cyc("f_full"); fifo_full = 1'b0; end
            else cyc("f_full");
            chk("f_full_stall", 32'(dut_vec()), 32'(V_FULL));
        end
        cyc("f_laf");
        chk("f_laf", 32'(dut_vec()), 32'(V_LAF));
        cyc("f_resume");
        chk("f_ld_again", 32'(dut_vec()), 32'(V_LD));
        pkt_valid = 1'b0;
        cyc("f_par");
        cyc("f_chk");
        cyc("f_done");
        chk("f_detect", 32'(dut_vec()), 32'(V_DET));

        // port 2 not empty: wait, then empty releases the header
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        cyc("w_hdr");
        chk("w_wait_busy", 32'(dut_vec()), 32'(V_WAIT));
        pkt_valid = 1'b0;
        cyc("w_hold");
        chk("w_still_wait", 32'(dut_vec()), 32'(V_WAIT));
        fifo_empty_2 = 1'b1;
        cyc("w_release");
        chk("w_lfd", 32'(dut_vec()), 32'(V_LFD));
        cyc("w_ld");
        cyc("w_par");
        cyc("w_chk");
        cyc("w_done");
        chk("w_detect", 32'(dut_vec()), 32'(V_DET));

        // invalid address 3 is ignored
        pkt_valid = 1'b1; data_in = 2'd3;
        cyc("inv0");
        chk("inv_stays", 32'(dut_vec()), 32'(V_DET));
        cyc("inv1");
        chk("inv_stays2", 32'(dut_vec()), 32'(V_DET));

        // soft reset of the selected port aborts; of another port does nothing
        data_in = 2'd0; fifo_empty_0 = 1'b1;
        cyc("s_hdr");
        cyc("s_ld");
        soft_reset_0 = 1'b1;
        cyc("s_abort");
        chk("s_abort_detect", 32'(dut_vec()), 32'(V_DET));
        soft_reset_0 = 1'b0;
        cyc("s_hdr2");
        cyc("s_ld2");
        soft_reset_1 = 1'b1;
        cyc("s_other");
        chk("s_other_ignored", 32'(dut_vec()), 32'(V_LD));
        soft_reset_1 = 1'b0; pkt_valid = 1'b0;
        cyc("s_par");
        cyc("s_chk");
        cyc("s_done");

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        // timeout after LIMIT wait cycles with a one-cycle pulse
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b0;
        cyc("t_hdr");
        pkt_valid = 1'b0;
        for (int i = 0; i < LIMIT - 1; i++) begin
            cyc("t_wait");
            chk("t_wait_no_pulse", 32'(dut_vec()), 32'(V_WAIT));
        end
        cyc("t_expire");
        chk("t_pulse", 32'(dut_vec()), 32'(V_DETT));
        cyc("t_after");
        chk("t_pulse_one_cycle", 32'(dut_vec()), 32'(V_DET));
        // empty on the limit cycle wins
        pkt_valid = 1'b1;
        cyc("t2_hdr");
        pkt_valid = 1'b0;
        for (int i = 0; i < LIMIT - 1; i++) cyc("t2_wait");
        fifo_empty_1 = 1'b1;
        cyc("t2_edge");
        chk("t2_empty_wins", 32'(dut_vec()), 32'(V_LFD));
        cyc("t2_ld");
        cyc("t2_par");
        cyc("t2_chk");
        cyc("t2_done");
`endif

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            resetn        = ($urandom_range(0, 99) != 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 4) == 0);
            fifo_empty_0  = ($urandom_range(0, 2) != 0);
            fifo_empty_1  = ($urandom_range(0, 2) != 0);
            fifo_empty_2  = ($urandom_range(0, 3) == 0);
            soft_reset_0  = ($urandom_range(0, 49) == 0);
            soft_reset_1  = ($urandom_range(0, 49) == 0);
            soft_reset_2  = ($urandom_range(0, 49) == 0);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 3) == 0);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
